// File: rtl/tile_ram_write_sequencer.sv
// tile_ram_write_sequencer: arbitrates single-cell and bulk (clear/fill) writes onto tile RAM port A
module tile_ram_write_sequencer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 8,
    parameter bit BLANK_ONLY = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       video_on,
    input  logic       clear_req,
    input  logic       fill_req,
    input  logic [1:0] fill_code,
    input  logic       wr_req,
    input  logic [6:0] wr_x,
    input  logic [2:0] wr_y,
    input  logic [1:0] wr_code,
    output logic       wr_ack,
    output logic       err_tick,
    output logic       we,
    output logic [9:0] waddr,
    output logic [2:0] wdata,
    output logic       busy,
    output logic       done_tick
);
    typedef enum logic [1:0] {IDLE, CLEAR, FILL} state_t;

    state_t     state, state_nx, mode;
    logic [6:0] x, x_nx, bx;
    logic [2:0] y, y_nx, by;
    logic [1:0] fcode, fcode_nx;
    logic       start_clr, start_fill, bulk, issue, last, single, in_range;
    logic       we_nx, wr_ack_nx, err_nx, busy_nx, done_nx;
    logic [9:0] waddr_nx;
    logic [2:0] wdata_nx;

    // state, scan position, latched fill code and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            fcode     <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            wr_ack    <= 1'b0;
            err_tick  <= 1'b0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            state     <= state_nx;
            x         <= x_nx;
            y         <= y_nx;
            fcode     <= fcode_nx;
            we        <= we_nx;
            waddr     <= waddr_nx;
            wdata     <= wdata_nx;
            wr_ack    <= wr_ack_nx;
            err_tick  <= err_nx;
            busy      <= busy_nx;
            done_tick <= done_nx;
        end
    end

    // next state: bulk starts reset the scan to (0,0) so the first cell is written next cycle
    always_comb begin
        start_clr  = clear_req && state != CLEAR;
        start_fill = fill_req && !clear_req && state == IDLE;
        mode       = start_clr ? CLEAR : start_fill ? FILL : state;
        bx         = (start_clr || start_fill) ? 7'd0 : x;
        by         = (start_clr || start_fill) ? 3'd0 : y;
        bulk       = mode != IDLE;
        issue      = bulk && !(BLANK_ONLY && video_on);
        last       = int'(bx) == COLS - 1 && int'(by) == ROWS - 1;
        fcode_nx   = start_fill ? fill_code : fcode;
        state_nx   = (issue && last) ? IDLE : mode;
        x_nx       = !issue ? bx : (int'(bx) == COLS - 1 ? 7'd0 : bx + 7'd1);
        y_nx       = (issue && int'(bx) == COLS - 1) ? by + 3'd1 : by;
    end

    // next outputs: bulk write wins, otherwise a single write only when no bulk request is present
    always_comb begin
        single    = state == IDLE && !clear_req && !fill_req && wr_req;
        in_range  = int'(wr_x) < COLS && int'(wr_y) < ROWS;
        we_nx     = issue || (single && in_range);
        waddr_nx  = issue ? {by, bx} : single ? {wr_y, wr_x} : 10'd0;
        wdata_nx  = issue ? (mode == CLEAR ? 3'b000 : {1'b1, fcode_nx})
                  : single ? {1'b1, wr_code} : 3'b000;
        wr_ack_nx = single;
        err_nx    = single && !in_range;
        busy_nx   = bulk;
        done_nx   = issue && last;
    end
endmodule

// File: doc/tile_ram_write_sequencer.md
Name: tile_ram_write_sequencer

Overview:
- Owns the write port (port A) of the 80x8 tile RAM that drives the square-wave VGA display.
- Arbitrates between two sources: single-cell writes from the cursor/key logic, and bulk screen operations (clear, fill) issued by control logic.
- Produces one registered write-port command per cycle (we, waddr, wdata). The display keeps reading port B independently.

Parameters:
- COLS, 80, number of tile columns; x index 0..COLS-1 (fits 7 bits).
- ROWS, 8, number of tile rows; y index 0..ROWS-1 (fits 3 bits).
- BLANK_ONLY, 0, when 1, bulk writes advance only while video_on=0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- video_on  in  1  high during the active display area
- clear_req  in  1  one-cycle pulse: clear the whole screen
- fill_req  in  1  one-cycle pulse: fill the whole screen with fill_code
- fill_code  in  2  wave code for a fill; sampled when fill_req is accepted
- wr_req  in  1  level request for a single-cell write; held until wr_ack
- wr_x  in  7  column of the single write
- wr_y  in  3  row of the single write
- wr_code  in  2  wave code of the single write
- wr_ack  out  1  one-cycle pulse: single write accepted
- err_tick  out  1  one-cycle pulse: single write out of range, dropped
- we  out  1  RAM write enable
- waddr  out  10  RAM write address, {y[2:0], x[6:0]}
- wdata  out  3  RAM write data, {on, code[1:0]}
- busy  out  1  a bulk operation is in progress
- done_tick  out  1  one-cycle pulse on the last write of a bulk operation

Behaviour:
- Reset: all outputs 0, state IDLE, x/y counters 0, latched fill code 0. This holds regardless of the current state, including mid-operation.
- All outputs are registered. A request sampled in cycle N produces its effect in cycle N+1.
- States: IDLE, CLEAR, FILL.
- IDLE priority (evaluated per cycle):
  - clear_req first, then fill_req, then wr_req.
  - Only one request is accepted per cycle.
  - A bulk request that loses arbitration in IDLE is dropped; bulk requests are pulses and are not queued.
- Single write (IDLE, wr_req=1, no bulk request that cycle):
  - In-range (wr_x<COLS and wr_y<ROWS): next cycle we=1, waddr={wr_y,wr_x}, wdata={1,wr_code}, wr_ack=1.
  - Out of range: next cycle wr_ack=1, err_tick=1, we=0.
  - Requester must drop wr_req in the cycle wr_ack is seen. If wr_req is still high, it is treated as a new request.
- Bulk entry: on accepting clear_req or fill_req, load x=0, y=0; enter CLEAR or FILL. fill_code is latched into the fill-code register for FILL.
- Bulk write cycle: busy=1, waddr={y,x}.
  - CLEAR: wdata=3'b000.
  - FILL: wdata={1, latched fill_code}.
  - we=1 unless BLANK_ONLY=1 and video_on=1. In that case we=0 and x/y hold.
  - The first write occurs in the cycle after acceptance.
- Scan order: x increments 0..COLS-1; at x=COLS-1, x wraps to 0 and y increments. Addresses with x>=COLS are never issued.
- Last cell (y=ROWS-1, x=COLS-1): that write cycle also asserts done_tick=1. State returns to IDLE the next cycle with busy=0.
- Ungated bulk operation: exactly COLS*ROWS = 640 consecutive we cycles.
- During CLEAR/FILL: wr_ack stays 0 and wr_req is held off.
- clear_req during FILL: the fill is aborted. The next cycle restarts at x=0, y=0 in CLEAR. No done_tick is issued for the aborted fill.
- fill_req during FILL, or any bulk request during CLEAR: ignored.
- done_tick and wr_ack are never asserted in the same cycle.
- busy falls in the cycle after done_tick. A wr_req pending since the bulk operation started is accepted in the first IDLE cycle.

Test Plan:
- Reset, then wr_req with x=5, y=2, code=2 -> one cycle later: we=1, waddr=0x105, wdata=3'b110, wr_ack=1 for exactly one cycle.
- wr_req with x=80, y=0 -> wr_ack=1, err_tick=1, we=0; RAM model unchanged.
- clear_req pulse, video_on=0 -> 640 consecutive we cycles with wdata=0. First waddr=0x000; waddr 0x04F is followed by 0x080; last waddr 0x3CF coincides with done_tick; busy falls next cycle.
- fill_req with code=1 and BLANK_ONLY=1; video_on toggles 100 cycles high / 60 low -> writes only while video_on=0, addresses contiguous across gaps, 640 total writes, all wdata=3'b101.
- fill_req, then at write 300 clear_req plus a held wr_req -> fill aborts with no done_tick; clear restarts at 0x000 and completes 640 writes; wr_ack pulses only after busy falls.
- Assert reset_n=0 at clear write 200 -> all outputs 0 immediately. After release, state is IDLE and a subsequent single write is acked normally.
